vram_scan_arbiter: RTL and testbench
====================================

Name: vram_scan_arbiter

Overview:
- Shares one single-port, pipelined video RAM between VGA scanout and the CPU data bus.
- Consumes line_num/pixel_num/avr from the VGA timing generator and schedules a video read every 4 pixel clocks, one word ahead of display.
- Unpacks each word into a registered 4-bit pixel colour.
- The CPU gets every memory cycle that video does not claim.

Parameters:
- H_VIS, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_VIS, 480, visible lines
- V_TOTAL, 525, lines per frame
- BPP, 4, bits per pixel
- DATA_W, 16, RAM word width; PPW = DATA_W/BPP = 4 pixels per word
- ADDR_W, 17, RAM word-address width
- FB_BASE, 0, framebuffer base word address

Ports:
- clk  in  1  pixel clock (same clock as timing generator)
- rst  in  1  asynchronous, active-high reset
- line_num  in  10  current line from timing generator
- pixel_num  in  10  current pixel from timing generator
- avr  in  1  active video region
- pix_color  out  BPP  registered pixel colour
- pix_valid  out  1  avr delayed 1 clk
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  write data
- cpu_ack  out  1  one-clk completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack for reads
- mem_addr  out  ADDR_W  RAM address (combinational from current grant)
- mem_en  out  1  RAM command valid this cycle
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 clk after a read command

Behaviour:
- Reset: pix_color=0, pix_valid=0, cpu_ack=0, cpu_rdata=0, prefetch and cur_word=0, rd_owner=NONE, mem_en=0, mem_we=0.
- Reset mid-access: any in-flight read is discarded and no ack is produced. A CPU request still held high is re-issued after reset release.
- RAM model: at most one command per clk. Read data returns on mem_rdata in the next clk.
- Video slot: cycle with pixel_num[1:0]==1. A read is issued in two cases:
  - Visible case: pixel_num<H_VIS, (pixel_num>>2)+1 < H_VIS/PPW, and line_num<V_VIS. Fetch word (pixel_num>>2)+1 of line_num.
  - Line-prefetch case: pixel_num==H_TOTAL-3. Fetch word 0 of next line, where next = (line_num==V_TOTAL-1) ? 0 : line_num+1. Suppressed when next>=V_VIS.
- Video address: FB_BASE + line*(H_VIS/PPW) + word, computed at ADDR_W bits; overflow truncates.
- Arbiter FSM, per clk:
  - IDLE: video slot → issue video read, rd_owner=VID.
  - IDLE, else if cpu_req && !cpu_ack → issue CPU access; read sets rd_owner=CPU, write sets rd_owner=CPUW.
  - CAPTURE (the clk after any issue): VID → prefetch<=mem_rdata. CPU → cpu_rdata<=mem_rdata and cpu_ack=1. CPUW → cpu_ack=1. A new command may be issued in the same clk under the IDLE rules (pipelined).
  - Video always wins. A CPU request coincident with a video slot waits exactly 1 clk.
  - No CPU issue is allowed in a clk where cpu_ack is high, so the CPU peak rate is 1 access per 2 clks.
- Unpacking: pixel j of a word occupies bits [BPP*j+BPP-1 : BPP*j], with j=0 leftmost.
  - At the edge ending a cycle with avr=1 and pixel_num[1:0]==0: cur_word<=prefetch and pix_color<=prefetch[BPP-1:0].
  - At other avr=1 cycles: pix_color<=cur_word nibble pixel_num[1:0].
  - When avr=0: pix_color<=0.
- Output timing: pix_valid/pix_color lag pixel_num/avr by exactly 1 clk.
- Boundaries:
  - The last word of a line triggers no in-line fetch.
  - The line-prefetch at line V_TOTAL-1 targets line 0.
  - Lines V_VIS..V_TOTAL-1 issue no video reads, so the CPU has full bandwidth.

Decomposition:
- Shared package vga_pkg: H_VIS/H_TOTAL/V_VIS/V_TOTAL constants (shared with the timing generator), PPW, rd_owner encoding (NONE/VID/CPU/CPUW).
- One sub-module, vram_addr_calc: line/word → word address (multiply by H_VIS/PPW, add FB_BASE).

Test Plan:
- Reset with rst asserted asynchronously mid-line → all outputs 0 immediately; no ack for an in-flight CPU read.
- Preload word line0/w0=16'h3210, w1=16'h7654; drive pixel_num 0..7 on line 0 → pix_color sequence 0,1,2,3,4,5,6,7, each 1 clk after its pixel_num.
- pixel_num=797 (H_TOTAL-3) on line 0 → mem_addr=FB_BASE+160 (line 1, word 0), mem_we=0. At line 524 → mem_addr=FB_BASE+0. At line 479 → no video read.
- cpu_req read of addr 5 asserted in a video slot (pixel_num=1) → video read issued first; CPU read issued next clk; cpu_ack with cpu_rdata=RAM[5] one clk later.
- CPU write addr 100, data 16'hBEEF, during line 490 → mem_we=1 for one clk, cpu_ack the next clk; subsequent read returns 16'hBEEF.
- cpu_req held high continuously over a visible line → no CPU issue ever coincides with a video slot; acks at most every 2 clks; display pixels unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and the read-owner encoding for the VRAM scan arbiter.
// The timing constants are shared with the VGA timing generator.
package vga_pkg;

   localparam int H_VIS          = 640;   // visible pixels per line
   localparam int H_TOTAL        = 800;   // pixel clocks per line
   localparam int V_VIS          = 480;   // visible lines
   localparam int V_TOTAL        = 525;   // lines per frame
   localparam int PIX_BPP        = 4;     // bits per pixel
   localparam int WORD_W         = 16;    // RAM word width
   localparam int PPW            = WORD_W / PIX_BPP;   // pixels per RAM word
   localparam int WORDS_PER_LINE = H_VIS / PPW;

   // Who owns the read data returning on mem_rdata in the next clock.
   // OWN_NONE doubles as the idle state of the arbiter.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_CPUW = 2'd3
   } rd_owner_t;

endpackage

// File: rtl/vram_scan_arbiter_if.sv
// CPU data bus and pipelined single-port RAM bus of the VRAM scan arbiter.
//
// Handshake: the CPU raises cpu_req with cpu_we/cpu_addr/cpu_wdata stable and
// keeps them stable until it sees cpu_ack, a one-clock completion pulse
// (cpu_rdata is valid with cpu_ack for reads). The RAM accepts one command in
// every clock mem_en is high, with no back-pressure, and returns read data on
// mem_rdata in the following clock.
interface vram_scan_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 16
);

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_en;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side: serves the CPU, drives the RAM.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_ack, cpu_rdata, mem_addr, mem_en, mem_we, mem_wdata
   );

   // Environment side: the CPU and the RAM.
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_ack, cpu_rdata, mem_addr, mem_en, mem_we, mem_wdata
   );

endinterface

// File: rtl/vram_addr_calc.sv
// Framebuffer line/word to RAM word address. Arithmetic is done at ADDR_W
// bits, so an oversized framebuffer wraps rather than widening the bus.
module vram_addr_calc #(
   parameter int ADDR_W     = 17,
   parameter int FB_BASE    = 0,
   parameter int LINE_WORDS = 160,
   parameter int WORD_IDX_W = 8
) (
   input  logic [9:0]            i_line,
   input  logic [WORD_IDX_W-1:0] i_word,
   output logic [ADDR_W-1:0]     o_addr
);

   // base + line * words-per-line + word, truncated to ADDR_W
   assign o_addr = ADDR_W'(FB_BASE)
                 + ADDR_W'(i_line) * ADDR_W'(LINE_WORDS)
                 + ADDR_W'(i_word);

endmodule

// File: rtl/vram_scan_arbiter.sv
// Shares one pipelined single-port VRAM between VGA scanout and the CPU.
// Video reads are scheduled on pixel_num[1:0]==1, one word ahead of display;
// the CPU gets every other command slot. Each fetched word is unpacked into a
// registered pixel colour that lags pixel_num/avr by one clock.
module vram_scan_arbiter
   import vga_pkg::*;
#(
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = WORD_W,
   parameter int BPP     = PIX_BPP,
   parameter int FB_BASE = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [9:0]     line_num,
   input  logic [9:0]     pixel_num,
   input  logic           avr,
   output logic [BPP-1:0] pix_color,
   output logic           pix_valid,
   vram_scan_arbiter_if.slave bus,
   output rd_owner_t      o_dbg_owner
);

   localparam int LINE_WORDS = H_VIS / (DATA_W / BPP);

   localparam logic [9:0] C_H_VIS      = 10'(H_VIS);
   localparam logic [9:0] C_PRE_PIX    = 10'(H_TOTAL - 3);
   localparam logic [9:0] C_V_VIS      = 10'(V_VIS);
   localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] C_LINE_WORDS = 10'(LINE_WORDS);

   rd_owner_t         r_owner;
   rd_owner_t         w_owner_nxt;
   logic [DATA_W-1:0] r_prefetch;
   logic [DATA_W-1:0] r_cur_word;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [BPP-1:0]    r_pix_color;
   logic              r_pix_valid;

   logic [9:0]        w_word_nxt;
   logic [9:0]        w_line_nxt;
   logic              w_vis_slot;
   logic              w_pre_slot;
   logic              w_vid_req;
   logic [9:0]        w_vid_line;
   logic [7:0]        w_vid_word;
   logic [ADDR_W-1:0] w_vid_addr;
   logic              w_cpu_ack;
   logic              w_mem_en;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   // Video slot decode: in-line fetch of the next word, or word 0 of the next line
   assign w_word_nxt = {2'b00, pixel_num[9:2]} + 10'd1;
   assign w_line_nxt = (line_num == C_V_LAST) ? 10'd0 : line_num + 10'd1;
   assign w_vis_slot = (pixel_num[1:0] == 2'd1) && (pixel_num < C_H_VIS)
                    && (w_word_nxt < C_LINE_WORDS) && (line_num < C_V_VIS);
   assign w_pre_slot = (pixel_num == C_PRE_PIX) && (w_line_nxt < C_V_VIS);
   assign w_vid_req  = w_vis_slot || w_pre_slot;
   assign w_vid_line = w_pre_slot ? w_line_nxt : line_num;
   assign w_vid_word = w_pre_slot ? 8'd0 : w_word_nxt[7:0];

   vram_addr_calc #(
      .ADDR_W     (ADDR_W),
      .FB_BASE    (FB_BASE),
      .LINE_WORDS (LINE_WORDS),
      .WORD_IDX_W (8)
   ) u_addr_calc (
      .i_line (w_vid_line),
      .i_word (w_vid_word),
      .o_addr (w_vid_addr)
   );

   // The clock after a CPU issue is its completion clock; blocking a new CPU
   // issue here keeps a still-held cpu_req from being issued twice.
   assign w_cpu_ack = (r_owner == OWN_CPU) || (r_owner == OWN_CPUW);

   // Arbiter next-state and RAM command: video first, then a pending CPU access
   always_comb begin
      w_owner_nxt = OWN_NONE;
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (!rst) begin
         if (w_vid_req) begin
            w_mem_en    = 1'b1;
            w_mem_addr  = w_vid_addr;
            w_owner_nxt = OWN_VID;
         end else if (bus.cpu_req && !w_cpu_ack) begin
            w_mem_en    = 1'b1;
            w_mem_we    = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
            w_owner_nxt = bus.cpu_we ? OWN_CPUW : OWN_CPU;
         end
      end
   end

   // Arbiter state: owner of the command issued in the previous clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_owner <= OWN_NONE;
      else     r_owner <= w_owner_nxt;
   end

   // Capture returning read data for whoever issued the read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prefetch  <= '0;
         r_cpu_rdata <= '0;
      end else begin
         if (r_owner == OWN_VID) r_prefetch  <= bus.mem_rdata;
         if (r_owner == OWN_CPU) r_cpu_rdata <= bus.mem_rdata;
      end
   end

   // Pixel unpack: load a new word on slot 0, then walk its nibbles left to right
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur_word  <= '0;
         r_pix_color <= '0;
         r_pix_valid <= 1'b0;
      end else begin
         r_pix_valid <= avr;
         if (avr && (pixel_num[1:0] == 2'd0)) begin
            r_cur_word  <= r_prefetch;
            r_pix_color <= r_prefetch[BPP-1:0];
         end else if (avr) begin
            r_pix_color <= r_cur_word[BPP*int'(pixel_num[1:0]) +: BPP];
         end else begin
            r_pix_color <= '0;
         end
      end
   end

   assign bus.mem_en    = w_mem_en;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.cpu_ack   = w_cpu_ack;
   // Read data goes straight through in the ack clock and is held afterwards
   assign bus.cpu_rdata = (r_owner == OWN_CPU) ? bus.mem_rdata : r_cpu_rdata;
   assign pix_color     = r_pix_color;
   assign pix_valid     = r_pix_valid;
   assign o_dbg_owner   = r_owner;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Bench for vram_scan_arbiter: RAM model, pixel and CPU scoreboards, directed
// scenarios plus a free-running CPU read stream across a visible line.
module tb_vram_scan_arbiter;
   import vga_pkg::*;

   logic       clk;
   logic       rst;
   logic [9:0] line_num;
   logic [9:0] pixel_num;
   logic       avr;
   logic [3:0] pix_color;
   logic       pix_valid;
   rd_owner_t  dbg_owner;

   vram_scan_arbiter_if #(.ADDR_W(17), .DATA_W(16)) bus ();

   vram_scan_arbiter #(
      .ADDR_W  (17),
      .DATA_W  (16),
      .BPP     (4),
      .FB_BASE (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .line_num    (line_num),
      .pixel_num   (pixel_num),
      .avr         (avr),
      .pix_color   (pix_color),
      .pix_valid   (pix_valid),
      .bus         (bus),
      .o_dbg_owner (dbg_owner)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- RAM model ----------------
   logic [15:0] ram [0:131071];

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
         else            bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] pattern(input int a);
      return 16'(a) ^ 16'h5A5A;
   endfunction

   function automatic bit m_vid(input int ln, input int px, output int addr);
      int nxt;
      addr = 0;
      if ((px % 4 == 1) && (px < 640) && (px / 4 + 1 < 160) && (ln < 480)) begin
         addr = ln * 160 + px / 4 + 1;
         return 1'b1;
      end
      if (px == 797) begin
         nxt = (ln == 524) ? 0 : ln + 1;
         if (nxt < 480) begin
            addr = nxt * 160;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_pix(input int ln, input int px);
      logic [15:0] w;
      w = ram[ln * 160 + px / 4];
      return w[4 * (px % 4) +: 4];
   endfunction

   // ---------------- scoreboards ----------------
   logic [3:0]  exp_q[$];   // expected pixel colours, in display order
   logic [16:0] cpu_q[$];   // {is_read, expected read data} per CPU request

   int  cyc          = 0;
   int  last_ack_cyc = -10;
   int  ack_cnt      = 0;
   bit  ack_flag     = 1'b0;
   logic avr_d;
   logic [3:0]  pix_e;
   logic [16:0] cpu_e;
   int  vaddr;

   always @(posedge clk) cyc++;

   always @(posedge clk or posedge rst) begin
      if (rst) avr_d <= 1'b0;
      else     avr_d <= avr;
   end

   always @(negedge clk) begin
      if (!rst) begin
         // RAM command for this clock
         if (m_vid(int'(line_num), int'(pixel_num), vaddr)) begin
            chk("vid_en",   32'(bus.mem_en), 32'd1);
            chk("vid_we",   32'(bus.mem_we), 32'd0);
            chk("vid_addr", 32'(bus.mem_addr), 32'(vaddr));
         end else if (!bus.cpu_req) begin
            chk("mem_idle", 32'(bus.mem_en), 32'd0);
         end else if (bus.mem_en) begin
            chk("cpu_cmd_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr));
            chk("cpu_cmd_we",   32'(bus.mem_we), 32'(bus.cpu_we));
            if (bus.cpu_we) chk("cpu_cmd_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
         end
         // pixel output
         chk("pix_valid", 32'(pix_valid), 32'(avr_d));
         if (pix_valid) begin
            chk("pix_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               pix_e = exp_q.pop_front();
               chk("pix_color", 32'(pix_color), 32'(pix_e));
            end
         end else begin
            chk("pix_blank", 32'(pix_color), 32'd0);
         end
         // CPU completion
         if (bus.cpu_ack) begin
            chk("ack_pending", 32'(cpu_q.size() > 0), 32'd1);
            chk("ack_gap", 32'(cyc - last_ack_cyc >= 2), 32'd1);
            if (cpu_q.size() > 0) begin
               cpu_e = cpu_q.pop_front();
               if (cpu_e[16]) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_e[15:0]));
            end
            last_ack_cyc = cyc;
            ack_cnt++;
            ack_flag = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int ln, input int px, input bit a);
      @(posedge clk);
      #1;
      line_num  = 10'(ln);
      pixel_num = 10'(px);
      avr       = a;
      if (a) exp_q.push_back(m_pix(ln, px));
   endtask

   task automatic cpu_read(input int a);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 17'(a);
      bus.cpu_wdata = 16'h0;
      cpu_q.push_back({1'b1, ram[a]});
   endtask

   task automatic cpu_write(input int a, input logic [15:0] d);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 17'(a);
      bus.cpu_wdata = d;
      cpu_q.push_back({1'b0, 16'h0});
   endtask

   // Free-running CPU: keeps cpu_req high, presenting a new read after each ack
   bit cpu_auto  = 1'b0;
   bit auto_busy = 1'b0;

   task automatic auto_read();
      int a;
      a = $urandom_range(60000, 1000);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 17'(a);
      bus.cpu_wdata = 16'h0;
      cpu_q.push_back({1'b1, pattern(a)});
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (auto_busy) begin
            if (ack_flag) begin
               ack_flag = 1'b0;
               if (cpu_auto) auto_read();
               else begin
                  bus.cpu_req = 1'b0;
                  auto_busy   = 1'b0;
               end
            end
         end else if (cpu_auto) begin
            ack_flag  = 1'b0;
            auto_read();
            auto_busy = 1'b1;
         end
      end
   end

   // ---------------- main sequence ----------------
   int base;

   initial begin
      rst           = 1'b1;
      line_num      = '0;
      pixel_num     = '0;
      avr           = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.mem_rdata = '0;
      for (int i = 0; i < 131072; i++) ram[i] = pattern(i);
      ram[0] = 16'h3210;
      ram[1] = 16'h7654;
      for (int w = 2; w < 160; w++) ram[w] = 16'($urandom);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pix_color", 32'(pix_color), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_cpu_ack",   32'(bus.cpu_ack), 32'd0);
      chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      chk("rst_mem_en",    32'(bus.mem_en), 32'd0);
      chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
      chk("rst_owner",     32'(dbg_owner), 32'(OWN_NONE));
      @(negedge clk);
      #1 rst = 1'b0;

      // line prefetch from the last line, then pixels 0..7 of line 0
      step(524, 797, 1'b0);
      step(524, 798, 1'b0);
      step(524, 799, 1'b0);
      for (int p = 0; p < 8; p++) step(0, p, 1'b1);

      // asynchronous reset during a CPU read in flight, mid-line
      step(0, 8, 1'b1);
      cpu_read(7);
      @(negedge clk);
      chk("inflight_issue_en",   32'(bus.mem_en), 32'd1);
      chk("inflight_issue_addr", 32'(bus.mem_addr), 32'd7);
      step(0, 9, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("async_pix_valid", 32'(pix_valid), 32'd0);
      chk("async_pix_color", 32'(pix_color), 32'd0);
      chk("async_cpu_ack",   32'(bus.cpu_ack), 32'd0);
      chk("async_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      chk("async_mem_en",    32'(bus.mem_en), 32'd0);
      chk("async_mem_we",    32'(bus.mem_we), 32'd0);
      exp_q.delete();
      step(490, 10, 1'b0);
      step(490, 11, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reissue_en",   32'(bus.mem_en), 32'd1);
      chk("reissue_addr", 32'(bus.mem_addr), 32'd7);
      step(490, 12, 1'b0);
      @(negedge clk);
      chk("reissue_ack", 32'(bus.cpu_ack), 32'd1);
      step(490, 13, 1'b0);
      bus.cpu_req = 1'b0;

      // line-prefetch targets
      step(0, 797, 1'b0);
      @(negedge clk);
      chk("pre_l1_en",   32'(bus.mem_en), 32'd1);
      chk("pre_l1_addr", 32'(bus.mem_addr), 32'd160);
      chk("pre_l1_we",   32'(bus.mem_we), 32'd0);
      step(524, 797, 1'b0);
      @(negedge clk);
      chk("pre_wrap_en",   32'(bus.mem_en), 32'd1);
      chk("pre_wrap_addr", 32'(bus.mem_addr), 32'd0);
      step(479, 797, 1'b0);
      @(negedge clk);
      chk("pre_none_en", 32'(bus.mem_en), 32'd0);

      // CPU read colliding with a video slot waits one clock
      step(0, 0, 1'b0);
      step(0, 1, 1'b0);
      cpu_read(5);
      @(negedge clk);
      chk("slot_vid_en",   32'(bus.mem_en), 32'd1);
      chk("slot_vid_addr", 32'(bus.mem_addr), 32'd1);
      step(0, 2, 1'b0);
      @(negedge clk);
      chk("slot_cpu_en",   32'(bus.mem_en), 32'd1);
      chk("slot_cpu_addr", 32'(bus.mem_addr), 32'd5);
      chk("slot_cpu_we",   32'(bus.mem_we), 32'd0);
      step(0, 3, 1'b0);
      @(negedge clk);
      chk("slot_cpu_ack",   32'(bus.cpu_ack), 32'd1);
      chk("slot_cpu_rdata", 32'(bus.cpu_rdata), 32'(ram[5]));
      step(0, 4, 1'b0);
      bus.cpu_req = 1'b0;

      // CPU write in blanking, then read back
      step(490, 20, 1'b0);
      cpu_write(100, 16'hBEEF);
      @(negedge clk);
      chk("wr_en",    32'(bus.mem_en), 32'd1);
      chk("wr_we",    32'(bus.mem_we), 32'd1);
      chk("wr_addr",  32'(bus.mem_addr), 32'd100);
      chk("wr_wdata", 32'(bus.mem_wdata), 32'hBEEF);
      step(490, 21, 1'b0);
      @(negedge clk);
      chk("wr_ack",         32'(bus.cpu_ack), 32'd1);
      chk("no_issue_on_ack", 32'(bus.mem_en), 32'd0);
      step(490, 22, 1'b0);
      bus.cpu_req = 1'b0;
      step(490, 23, 1'b0);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 17'd100;
      cpu_q.push_back({1'b1, 16'hBEEF});
      step(490, 24, 1'b0);
      @(negedge clk);
      chk("rb_ack",   32'(bus.cpu_ack), 32'd1);
      chk("rb_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
      step(490, 25, 1'b0);
      bus.cpu_req = 1'b0;

      // full visible line with the CPU hammering the bus
      cpu_auto = 1'b1;
      step(524, 797, 1'b0);
      step(524, 798, 1'b0);
      step(524, 799, 1'b0);
      for (int p = 0; p < 800; p++) step(0, p, p < 640);

      // blanking line: CPU gets one access every two clocks
      step(490, 0, 1'b0);
      @(negedge clk);
      #1 base = ack_cnt;
      for (int p = 1; p <= 40; p++) step(490, p, 1'b0);
      @(negedge clk);
      #1 chk("full_bw_acks", 32'(ack_cnt - base), 32'd20);

      cpu_auto = 1'b0;
      for (int k = 0; k < 20 && auto_busy; k++) @(posedge clk);
      chk("auto_drain", 32'(auto_busy), 32'd0);
      for (int p = 50; p < 54; p++) step(490, p, 1'b0);
      @(negedge clk);
      #1;
      chk("pix_q_empty", 32'(exp_q.size()), 32'd0);
      chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
